fp_acc_seq: RTL and testbench

FP_ACC_SEQ -- requirements
Module: fp_acc_seq

---
 rtl/fp_acc_seq.sv | 179 +++++++++++++++++
 tb/tb_fp_acc_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_acc_seq.sv
// rtl/fp_acc_seq.sv - fp8 sequential accumulator with addr_top adder and IDLE/ACC/DONE control

// fp8 adder {sign[7], exp[6:4], mant[3:0]}, bias 3, exp==0 subnormal.
// Truncates toward zero and saturates to the largest finite magnitude.
module addr_top (
   input  logic [7:0] in_a,
   input  logic [7:0] in_b,
   output logic [7:0] res,
   output logic       zero
);

   logic [7:0] big;
   logic [7:0] sml;
   logic [2:0] big_e;
   logic [2:0] sml_e;
   logic [2:0] diff;
   logic [7:0] big_s;
   logic [7:0] sml_s;
   logic [7:0] sml_sh;
   logic [8:0] r;
   logic [3:0] lz;
   logic       sgn;

   // order operands by magnitude, align the smaller one and add or subtract significands
   always_comb begin
      if (in_a[6:0] >= in_b[6:0]) begin
         big = in_a;
         sml = in_b;
      end else begin
         big = in_b;
         sml = in_a;
      end
      // subnormals share the exponent of the smallest normal
      big_e  = (big[6:4] == 3'd0) ? 3'd1 : big[6:4];
      sml_e  = (sml[6:4] == 3'd0) ? 3'd1 : sml[6:4];
      // significand with hidden bit at [7] and three guard bits below the mantissa
      big_s  = {|big[6:4], big[3:0], 3'b000};
      sml_s  = {|sml[6:4], sml[3:0], 3'b000};
      diff   = big_e - sml_e;
      sml_sh = sml_s >> diff;
      sgn    = big[7];
      if (big[7] ^ sml[7]) begin
         r = {1'b0, big_s} - {1'b0, sml_sh};
      end else begin
         r = {1'b0, big_s} + {1'b0, sml_sh};
      end
   end

   // leading-zero count of the low eight result bits
   always_comb begin
      lz = 4'd8;
      for (int i = 0; i < 8; i++) begin
         if (r[i]) begin
            lz = 4'(7 - i);
         end
      end
   end

   // renormalise: carry-out, normal left shift, or clamp into the subnormal range
   always_comb begin
      res = {sgn, 7'd0};
      if (r == 9'd0) begin
         res = {sgn, 7'd0};
      end else if (r[8]) begin
         if (big_e == 3'd7) begin
            res = {sgn, 7'h7F};
         end else begin
            res = {sgn, big_e + 3'd1, r[7:4]};
         end
      end else if ({1'b0, big_e} > lz) begin
         res = {sgn, big_e - lz[2:0], 4'((r[7:0] << lz) >> 3)};
      end else begin
         res = {sgn, 3'd0, 4'((r[7:0] << (big_e - 3'd1)) >> 3)};
      end
      zero = (res[6:0] == 7'd0);
   end

endmodule

module fp_acc_seq #(
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             clr,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [7:0]       sum,
   output logic             sum_zero,
   output logic             done,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [7:0]       acc;
   logic [7:0]       acc_nxt;
   logic [LEN_W-1:0] cnt;
   logic [LEN_W-1:0] cnt_nxt;
   logic [7:0]       add_res;
   logic             add_zero;

   addr_top u_addr (
      .in_a (acc),
      .in_b (in_data),
      .res  (add_res),
      .zero (add_zero)
   );

   // state, accumulator and remaining-operand counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         acc   <= 8'h00;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // next-state, datapath update and handshake outputs; clr overrides everything
   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      cnt_nxt   = cnt;
      in_ready  = 1'b0;
      done      = 1'b0;
      busy      = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            if (start) begin
               cnt_nxt   = len;
               acc_nxt   = 8'h00;
               state_nxt = (len == '0) ? S_DONE : S_ACC;
            end
         end
         S_ACC: begin
            in_ready = 1'b1;
            if (in_valid) begin
               // a zero sum is stored as +0 so -0 never reaches sum
               acc_nxt = add_zero ? 8'h00 : add_res;
               if (cnt != '0) begin
                  cnt_nxt = cnt - LEN_W'(1);
               end
               if (cnt <= LEN_W'(1)) begin
                  state_nxt = S_DONE;
               end
            end
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
      if (clr) begin
         state_nxt = S_IDLE;
         acc_nxt   = 8'h00;
         cnt_nxt   = '0;
      end
   end

   assign sum      = acc;
   assign sum_zero = (acc[6:0] == 7'd0);

endmodule

// File: tb/tb_fp_acc_seq.sv
// tb/tb_fp_acc_seq.sv - scoreboard bench for fp_acc_seq

module tb_fp_acc_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [3:0] len;
   logic       clr;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] sum;
   logic       sum_zero;
   logic       done;
   logic       busy;

   int         checks = 0;
   int         errors = 0;
   int         done_cnt = 0;
   logic [7:0] sb_q [$];
   logic [7:0] beats [16];
   logic [7:0] mids [16];
   bit         midv [16];

   fp_acc_seq #(.LEN_W(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .len      (len),
      .clr      (clr),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .sum      (sum),
      .sum_zero (sum_zero),
      .done     (done),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_tables;
      for (int i = 0; i < 16; i++) begin
         beats[i] = 8'h00;
         mids[i]  = 8'h00;
         midv[i]  = 1'b0;
      end
   endtask

   // completed jobs pop their expected sum from the scoreboard
   always @(negedge clk) begin
      if (rst_n && done) begin
         done_cnt++;
         check("sb_nonempty", 16'(sb_q.size() > 0), 16'd1);
         if (sb_q.size() > 0) begin
            check("sb_sum", sum, sb_q.pop_front());
         end
      end
   end

   task automatic run_job(input int n, input int gap, input logic [7:0] exp_sum, input string tag);
      int d0;
      sb_q.push_back(exp_sum);
      d0    = done_cnt;
      len   = 4'(n);
      start = 1'b1;
      tick;
      start = 1'b0;
      check({tag, "_busy"}, busy, 1);
      check({tag, "_rdy"}, in_ready, 16'(n > 0));
      for (int i = 0; i < n; i++) begin
         in_data  = beats[i];
         in_valid = 1'b1;
         tick;
         in_valid = 1'b0;
         in_data  = 8'h00;
         if (i < n - 1) begin
            check({tag, "_nodone"}, done, 0);
            if (midv[i]) check({tag, "_mid"}, sum, mids[i]);
            for (int g = 0; g < gap && i == 0; g++) begin
               if (g == 2) begin
                  start = 1'b1;
                  len   = 4'd0;
               end
               tick;
               start = 1'b0;
               check({tag, "_gap_sum"}, sum, mids[0]);
               check({tag, "_gap_rdy"}, in_ready, 1);
            end
         end
      end
      check({tag, "_done"}, done, 1);
      check({tag, "_sum"}, sum, exp_sum);
      check({tag, "_zero"}, sum_zero, 16'(exp_sum[6:0] == 7'd0));
      tick;
      check({tag, "_done_off"}, done, 0);
      check({tag, "_idle"}, busy, 0);
      check({tag, "_hold"}, sum, exp_sum);
      check({tag, "_done_once"}, 16'(done_cnt - d0), 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      rst_n    = 1'b0;
      start    = 1'b0;
      len      = 4'd0;
      clr      = 1'b0;
      in_data  = 8'h00;
      in_valid = 1'b0;
      #2;
      check("rst_busy", busy, 0);
      check("rst_rdy", in_ready, 0);
      check("rst_done", done, 0);
      check("rst_sum", sum, 8'h00);
      check("rst_zero", sum_zero, 1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick;

      clear_tables();
      beats[0] = 8'h15; beats[1] = 8'h0A;
      mids[0]  = 8'h15; midv[0]  = 1'b1;
      run_job(2, 0, 8'h1F, "two");

      clear_tables();
      beats[0] = 8'h15; beats[1] = 8'h0A; beats[2] = 8'h0A;
      mids[0]  = 8'h15; midv[0]  = 1'b1;
      mids[1]  = 8'h1F; midv[1]  = 1'b1;
      run_job(3, 0, 8'h24, "three");

      clear_tables();
      beats[0] = 8'h1F; beats[1] = 8'h9F;
      mids[0]  = 8'h1F; midv[0]  = 1'b1;
      run_job(2, 0, 8'h00, "cancel_a");

      clear_tables();
      beats[0] = 8'h24; beats[1] = 8'hA4;
      mids[0]  = 8'h24; midv[0]  = 1'b1;
      run_job(2, 0, 8'h00, "cancel_b");

      clear_tables();
      beats[0] = 8'h15; beats[1] = 8'h0A;
      mids[0]  = 8'h15; midv[0]  = 1'b1;
      run_job(2, 5, 8'h1F, "stall");

      clear_tables();
      run_job(0, 0, 8'h00, "len0");

      clear_tables();
      for (int i = 0; i < 15; i++) beats[i] = 8'h01;
      mids[0] = 8'h01; midv[0] = 1'b1;
      mids[7] = 8'h08; midv[7] = 1'b1;
      run_job(15, 0, 8'h0F, "maxlen");

      // clr after one beat, colliding with a beat and a start
      d0    = done_cnt;
      len   = 4'd3;
      start = 1'b1;
      tick;
      start    = 1'b0;
      in_data  = 8'h15;
      in_valid = 1'b1;
      tick;
      check("clr_pre_sum", sum, 8'h15);
      in_data = 8'h0A;
      clr     = 1'b1;
      start   = 1'b1;
      len     = 4'd2;
      tick;
      clr      = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      check("clr_busy", busy, 0);
      check("clr_rdy", in_ready, 0);
      check("clr_sum", sum, 8'h00);
      check("clr_zero", sum_zero, 1);
      repeat (3) tick;
      check("clr_nodone", 16'(done_cnt - d0), 0);
      check("clr_still_idle", busy, 0);

      // asynchronous reset between edges in the middle of a job
      len   = 4'd2;
      start = 1'b1;
      tick;
      start    = 1'b0;
      in_data  = 8'h15;
      in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      check("ar_pre_sum", sum, 8'h15);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_busy", busy, 0);
      check("ar_rdy", in_ready, 0);
      check("ar_done", done, 0);
      check("ar_sum", sum, 8'h00);
      check("ar_zero", sum_zero, 1);
      tick;
      rst_n = 1'b1;
      d0    = done_cnt;
      tick;
      check("ar_idle", busy, 0);
      check("ar_nodone", 16'(done_cnt - d0), 0);
      check("ar_nopartial", sum, 8'h00);

      clear_tables();
      beats[0] = 8'h15; beats[1] = 8'h0A;
      mids[0]  = 8'h15; midv[0]  = 1'b1;
      run_job(2, 0, 8'h1F, "after_rst");

      check("sb_drain", 16'(sb_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
